vram_scanout: RTL and testbench

//  Read-side master of the VRAM byte port: raster engine streaming the framebuffer to the display.

---
 rtl/vram_scanout_if.sv | 27 ++
 rtl/vram_scanout.sv | 166 ++++++++++++++++
 tb/tb_vram_scanout.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_scanout_if.sv
// VRAM scanout bus: groups the enable control, the VRAM read port and the
// video output signals of the raster engine.
// Latency: none (wires only).
// Backpressure: none; VRAM answers every read in one clk, the display never stalls.
//   master: the scanout engine (drives address/req and video, receives enable/read data)
//   slave : the environment (drives enable/read data, receives address/req and video)
interface vram_scanout_if;
    logic        enable;
    logic [19:0] vram_address;
    logic        vram_req;
    logic [7:0]  vram_r_data;
    logic [7:0]  pixel;
    logic        de;
    logic        hsync;
    logic        vsync;
    logic        frame_start;

    modport master (
        input  enable, vram_r_data,
        output vram_address, vram_req, pixel, de, hsync, vsync, frame_start
    );

    modport slave (
        output enable, vram_r_data,
        input  vram_address, vram_req, pixel, de, hsync, vsync, frame_start
    );
endinterface

// File: rtl/vram_scanout.sv
// Raster scanout: h/v timing, one VRAM byte fetch per active pixel, aligned RGB332 video out.
// Latency: every output trails the h/v counter state by 2 clk (address/req by 1 clk).
// Backpressure: none; VRAM must answer in 1 clk. Idle cycles (vram_req=0) are free for the CPU.
//   clk, rst       : clock, asynchronous active-high reset
//   bus.enable     : 1 = scan frames, 0 = stop after the current frame
//   bus.vram_*     : registered read address + live-fetch strobe, read data one clk later
//   bus.pixel/de/hsync/vsync/frame_start : video outputs, mutually aligned
module vram_scanout #(
    parameter int          H_ACTIVE  = 640,
    parameter int          H_FP      = 16,
    parameter int          H_SYNC    = 96,
    parameter int          H_BP      = 48,
    parameter int          V_ACTIVE  = 480,
    parameter int          V_FP      = 10,
    parameter int          V_SYNC    = 2,
    parameter int          V_BP      = 33,
    parameter logic [19:0] BASE_ADDR = 20'h00000,
    parameter int          PIX_DIV   = 1,
    parameter bit          HS_POL    = 1'b0,
    parameter bit          VS_POL    = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    vram_scanout_if.master bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // +1 so the region upper bounds (which may equal TOTAL) still fit the counter width
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);
    localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYN_LO = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYN_HI = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYN_LO = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYN_HI = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [DW-1:0] div_cnt;

    // ---------------- stage k: counter state decode ----------------
    logic live, div_zero, div_last, h_last, v_last, frame_last;
    logic act, fetch, hs_act, vs_act, first_pix;

    assign live       = (state != IDLE);
    assign div_zero   = (div_cnt == '0);
    assign div_last   = (div_cnt == DIV_LAST);
    assign h_last     = (h_cnt == H_LAST);
    assign v_last     = (v_cnt == V_LAST);
    assign frame_last = live && div_last && h_last && v_last;
    assign act        = live && (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign fetch      = act && div_zero;
    assign hs_act     = live && (h_cnt >= H_SYN_LO) && (h_cnt < H_SYN_HI);
    assign vs_act     = live && (v_cnt >= V_SYN_LO) && (v_cnt < V_SYN_HI);
    assign first_pix  = live && (h_cnt == '0) && (v_cnt == '0) && div_zero;

    // Counters wrap to (0,0) on the last pixel of a frame, so leaving for IDLE
    // there needs no extra clearing. Dropping enable on that very pixel goes
    // straight to IDLE: the frame is complete and DRAIN would start another one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            h_cnt   <= '0;
            v_cnt   <= '0;
            div_cnt <= '0;
        end else if (state == IDLE) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            div_cnt <= '0;
            state   <= bus.enable ? RUN : IDLE;
        end else begin
            if (div_last) begin
                div_cnt <= '0;
                if (h_last) begin
                    h_cnt <= '0;
                    v_cnt <= v_last ? '0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (frame_last)
                state <= bus.enable ? RUN : IDLE;
            else
                state <= bus.enable ? RUN : DRAIN;
        end
    end

    // ---------------- stage k+1: fetch address + decode delay ----------------
    logic [19:0] addr_q, ptr_q, fetch_addr;
    logic        req_q, de1, hs1, vs1, fs1;

    // Pixel (0,0) always restarts from BASE_ADDR; 20-bit adds wrap naturally.
    assign fetch_addr = ((h_cnt == '0) && (v_cnt == '0)) ? BASE_ADDR : ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= BASE_ADDR;
            ptr_q  <= BASE_ADDR;
            req_q  <= 1'b0;
            de1    <= 1'b0;
            hs1    <= 1'b0;
            vs1    <= 1'b0;
            fs1    <= 1'b0;
        end else begin
            req_q <= fetch;
            de1   <= act;
            hs1   <= hs_act;
            vs1   <= vs_act;
            fs1   <= first_pix;
            if (fetch) begin
                addr_q <= fetch_addr;
                ptr_q  <= fetch_addr + 20'd1;
            end else if (!live) begin
                addr_q <= BASE_ADDR;
                ptr_q  <= BASE_ADDR;
            end
        end
    end

    // ---------------- stage k+2: video outputs ----------------
    logic [7:0] pixel_q;
    logic       de_q, hsync_q, vsync_q, fs_q;

    // Read data is captured only on the clk after a live fetch; on the
    // remaining PIX_DIV-1 clks of an active pixel the byte is simply held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_q <= 8'h00;
            de_q    <= 1'b0;
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            fs_q    <= 1'b0;
        end else begin
            if (req_q)
                pixel_q <= bus.vram_r_data;
            else if (!de1)
                pixel_q <= 8'h00;
            de_q    <= de1;
            hsync_q <= hs1 ? HS_POL : ~HS_POL;
            vsync_q <= vs1 ? VS_POL : ~VS_POL;
            fs_q    <= fs1;
        end
    end

    assign bus.vram_address = addr_q;
    assign bus.vram_req     = req_q;
    assign bus.pixel        = pixel_q;
    assign bus.de           = de_q;
    assign bus.hsync        = hsync_q;
    assign bus.vsync        = vsync_q;
    assign bus.frame_start  = fs_q;

endmodule

// File: tb/tb_vram_scanout.sv
// Bench for vram_scanout: three instances on the small 8x6 raster
// (u0 base 0 / div 1, u1 base FFFFE / div 1, u2 base 0 / div 2 / positive syncs).
// VRAM content is mem[a] = a[7:0].
module tb_vram_scanout;

    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int          PD[3]   = '{1, 1, 2};
    localparam logic [19:0] BASE[3] = '{20'h00000, 20'hFFFFE, 20'h00000};
    localparam bit          POL[3]  = '{1'b0, 1'b0, 1'b1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   en[3];

    always #5 clk = ~clk;

    vram_scanout_if bus0 ();
    vram_scanout_if bus1 ();
    vram_scanout_if bus2 ();

    assign bus0.enable = en[0];
    assign bus1.enable = en[1];
    assign bus2.enable = en[2];

    vram_scanout #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                   .BASE_ADDR(20'h00000), .PIX_DIV(1), .HS_POL(1'b0), .VS_POL(1'b0))
        u0 (.clk(clk), .rst(rst), .bus(bus0));
    vram_scanout #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                   .BASE_ADDR(20'hFFFFE), .PIX_DIV(1), .HS_POL(1'b0), .VS_POL(1'b0))
        u1 (.clk(clk), .rst(rst), .bus(bus1));
    vram_scanout #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                   .BASE_ADDR(20'h00000), .PIX_DIV(2), .HS_POL(1'b1), .VS_POL(1'b1))
        u2 (.clk(clk), .rst(rst), .bus(bus2));

    // VRAM: reads on negedge, data valid at the following posedge.
    initial begin
        forever begin
            @(negedge clk);
            bus0.vram_r_data = bus0.vram_address[7:0];
            bus1.vram_r_data = bus1.vram_address[7:0];
            bus2.vram_r_data = bus2.vram_address[7:0];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        de, hs, vs, fs, req;
        logic [19:0] addr;
        logic [7:0]  pix;
    } exp_t;

    // What the raster must show c clks after scanning started.
    function automatic exp_t f_exp(input int pd, input logic [19:0] base, input int c);
        exp_t e;
        int p, sub, pf, h, v;
        e   = '0;
        p   = c / pd;
        sub = c % pd;
        pf  = p % (HT * VT);
        h   = pf % HT;
        v   = pf / HT;
        e.de   = (h < HA) && (v < VA);
        e.hs   = (h >= HA + HF) && (h < HA + HF + HS);
        e.vs   = (v >= VA + VF) && (v < VA + VF + VS);
        e.fs   = (pf == 0) && (sub == 0);
        e.req  = e.de && (sub == 0);
        e.addr = base + 20'(v * HA + h);
        e.pix  = e.de ? e.addr[7:0] : 8'h00;
        return e;
    endfunction

    // e0: counter-time expectation, e1: one clk later (address/req), e2: two clks later (video)
    exp_t e0[3], e1[3], e2[3];
    bit   run_m[3];
    int   cm[3];

    initial begin
        for (int k = 0; k < 3; k++) begin
            run_m[k] = 1'b0; cm[k] = 0; e0[k] = '0; e1[k] = '0; e2[k] = '0;
        end
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int k = 0; k < 3; k++) begin
                    run_m[k] = 1'b0; cm[k] = 0; e0[k] = '0; e1[k] = '0; e2[k] = '0;
                end
            end else begin
                for (int k = 0; k < 3; k++) begin
                    e2[k] = e1[k];
                    e1[k] = e0[k];
                    if (!run_m[k]) begin
                        if (en[k]) begin
                            run_m[k] = 1'b1;
                            cm[k]    = 0;
                        end
                    end else if ((cm[k] % (HT * VT * PD[k])) == HT * VT * PD[k] - 1 && !en[k]) begin
                        run_m[k] = 1'b0;
                    end else begin
                        cm[k] = cm[k] + 1;
                    end
                    e0[k] = run_m[k] ? f_exp(PD[k], BASE[k], cm[k]) : '0;
                end
            end
        end
    end

    // ---------------- per-cycle compare + logs for literal checks ----------------
    task automatic chk_inst(input int k, input logic de, input logic hs, input logic vs,
                            input logic fs, input logic req, input logic [19:0] ad,
                            input logic [7:0] px);
        chk($sformatf("u%0d.de", k), 32'(de), 32'(e2[k].de));
        chk($sformatf("u%0d.pixel", k), 32'(px), 32'(e2[k].pix));
        chk($sformatf("u%0d.hsync", k), 32'(hs), 32'(e2[k].hs ? POL[k] : !POL[k]));
        chk($sformatf("u%0d.vsync", k), 32'(vs), 32'(e2[k].vs ? POL[k] : !POL[k]));
        chk($sformatf("u%0d.frame_start", k), 32'(fs), 32'(e2[k].fs));
        chk($sformatf("u%0d.vram_req", k), 32'(req), 32'(e1[k].req));
        if (e1[k].req)
            chk($sformatf("u%0d.vram_address", k), 32'(ad), 32'(e1[k].addr));
    endtask

    int         ncyc = 0;
    int         a_idx = -1, c_idx = -1;
    logic [7:0] a_pix[48];
    logic       a_de[48], a_hs[48], a_vs[48];
    int         a_fs_t[$];
    logic [19:0] b_addr[$];
    logic [7:0]  b_pix[$];
    logic [7:0]  c_pix[8];
    int         c_de16 = 0, c_req96 = 0;
    bit         restart_arm = 1'b0;
    logic [7:0] restart_pix = 8'hEE;

    initial begin
        for (int i = 0; i < 48; i++) begin
            a_pix[i] = 8'hAA; a_de[i] = 1'bx; a_hs[i] = 1'bx; a_vs[i] = 1'bx;
        end
        for (int i = 0; i < 8; i++) c_pix[i] = 8'hAA;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!rst) begin
                chk_inst(0, bus0.de, bus0.hsync, bus0.vsync, bus0.frame_start,
                         bus0.vram_req, bus0.vram_address, bus0.pixel);
                chk_inst(1, bus1.de, bus1.hsync, bus1.vsync, bus1.frame_start,
                         bus1.vram_req, bus1.vram_address, bus1.pixel);
                chk_inst(2, bus2.de, bus2.hsync, bus2.vsync, bus2.frame_start,
                         bus2.vram_req, bus2.vram_address, bus2.pixel);

                if (a_idx < 0 && bus0.frame_start) a_idx = 0;
                if (a_idx >= 0 && a_idx < 48) begin
                    a_pix[a_idx] = bus0.pixel; a_de[a_idx] = bus0.de;
                    a_hs[a_idx] = bus0.hsync;  a_vs[a_idx] = bus0.vsync;
                    a_idx++;
                end
                if (bus0.frame_start && a_fs_t.size() < 4) a_fs_t.push_back(ncyc);

                if (bus1.vram_req && b_addr.size() < 4) b_addr.push_back(bus1.vram_address);
                if (bus1.de && b_pix.size() < 4) b_pix.push_back(bus1.pixel);

                if (c_idx < 0 && bus2.frame_start) c_idx = 0;
                if (c_idx >= 0 && c_idx < 96) begin
                    if (c_idx < 8)  c_pix[c_idx] = bus2.pixel;
                    if (c_idx < 16 && bus2.de) c_de16++;
                    if (bus2.vram_req) c_req96++;
                    c_idx++;
                end

                if (restart_arm && bus0.de) begin
                    restart_pix = bus0.pixel;
                    restart_arm = 1'b0;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    int     n, act_cnt, vs_cnt, vs_first, de8;
    logic [7:0] hs_pat;
    exp_t   pin;

    initial begin
        en[0] = 1'b0; en[1] = 1'b0; en[2] = 1'b0;

        // model pins
        pin = f_exp(1, 20'h00000, 5);
        chk("model_hs_at_h5", 32'(pin.hs), 32'd1);
        pin = f_exp(1, 20'hFFFFE, 2);
        chk("model_addr_wrap", 32'(pin.addr), 32'h00000);
        pin = f_exp(2, 20'h00000, 3);
        chk("model_div2_pix", 32'({pin.de, pin.req, pin.pix}), 32'h201);
        pin = f_exp(1, 20'h00000, 33);
        chk("model_vs_line4", 32'({pin.vs, pin.de}), 32'h2);

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_de", 32'(bus0.de), 32'd0);
        chk("rst_pixel", 32'(bus0.pixel), 32'd0);
        chk("rst_hsync", 32'(bus0.hsync), 32'd1);
        chk("rst_vsync", 32'(bus0.vsync), 32'd1);
        chk("rst_req", 32'(bus0.vram_req), 32'd0);
        chk("rst_fs", 32'(bus0.frame_start), 32'd0);
        chk("rst_addr_u1", 32'(bus1.vram_address), 32'hFFFFE);
        chk("rst_syncs_u2", 32'({bus2.hsync, bus2.vsync}), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // T1/T2/T4/T5: run all three
        en[0] = 1'b1; en[1] = 1'b1; en[2] = 1'b1;
        repeat (130) @(negedge clk);

        // T3: drop u0 enable at v=1, frame must complete then go quiet
        n = 0;
        while (!(run_m[0] && (cm[0] % 48) == 10) && n < 200) begin @(negedge clk); n++; end
        chk("t3_reach_v1", 32'(n < 200), 32'd1);
        en[0] = 1'b0;
        n = 0;
        while (run_m[0] && n < 100) begin @(negedge clk); n++; end
        chk("t3_frame_len_after_drop", 32'(n), 32'd38);
        repeat (3) @(negedge clk);
        act_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            act_cnt += int'(bus0.de) + int'(bus0.vram_req) + int'(bus0.frame_start)
                     + int'(bus0.hsync !== 1'b1) + int'(bus0.vsync !== 1'b1);
            @(negedge clk);
        end
        chk("t3_idle_activity", 32'(act_cnt), 32'd0);

        // T1 literals on the first logged frame of u0
        for (int i = 0; i < 4; i++) chk($sformatf("t1_line0_pix%0d", i), 32'(a_pix[i]), 32'(i));
        for (int i = 0; i < 4; i++) chk($sformatf("t1_line1_pix%0d", i), 32'(a_pix[8 + i]), 32'(4 + i));
        de8 = 0;
        hs_pat = 8'h00;
        for (int i = 0; i < 8; i++) begin
            de8 += int'(a_de[i] === 1'b1);
            hs_pat[i] = (a_hs[i] === 1'b0);
        end
        chk("t1_de_per_line", 32'(de8), 32'd4);
        chk("t1_hsync_pattern", 32'(hs_pat), 32'h60);
        // T2
        vs_cnt = 0; vs_first = -1;
        for (int i = 0; i < 48; i++) begin
            if (a_vs[i] === 1'b0) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = i;
            end
        end
        chk("t2_vsync_len", 32'(vs_cnt), 32'd8);
        chk("t2_vsync_first", 32'(vs_first), 32'd32);
        chk("t2_fs_seen", 32'(a_fs_t.size() >= 2), 32'd1);
        if (a_fs_t.size() >= 2) chk("t2_fs_period", 32'(a_fs_t[1] - a_fs_t[0]), 32'd48);
        // T4
        chk("t4_addr_count", 32'(b_addr.size()), 32'd4);
        chk("t4_pix_count", 32'(b_pix.size()), 32'd4);
        if (b_addr.size() == 4) begin
            chk("t4_addr0", 32'(b_addr[0]), 32'hFFFFE);
            chk("t4_addr1", 32'(b_addr[1]), 32'hFFFFF);
            chk("t4_addr2", 32'(b_addr[2]), 32'h00000);
            chk("t4_addr3", 32'(b_addr[3]), 32'h00001);
        end
        if (b_pix.size() == 4) begin
            chk("t4_pix0", 32'(b_pix[0]), 32'hFE);
            chk("t4_pix3", 32'(b_pix[3]), 32'h01);
        end
        // T5
        for (int i = 0; i < 8; i++) chk($sformatf("t5_pix%0d", i), 32'(c_pix[i]), 32'(i / 2));
        chk("t5_de_per_line", 32'(c_de16), 32'd8);
        chk("t5_req_per_frame", 32'(c_req96), 32'd12);

        // T6: restart u0, reset mid-line between edges
        en[0] = 1'b1;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        chk("t6_pre_de", 32'(bus0.de), 32'd1);
        chk("t6_pre_pixel", 32'(bus0.pixel), 32'd2);
        #1 rst = 1'b1;
        #1;
        chk("t6_de", 32'(bus0.de), 32'd0);
        chk("t6_pixel", 32'(bus0.pixel), 32'd0);
        chk("t6_syncs", 32'({bus0.hsync, bus0.vsync}), 32'h3);
        chk("t6_req", 32'(bus0.vram_req), 32'd0);
        chk("t6_addr", 32'(bus0.vram_address), 32'd0);
        chk("t6_u2_syncs", 32'({bus2.hsync, bus2.vsync}), 32'd0);
        restart_arm = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("t6_restart_pix", 32'(restart_pix), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
